// File: rtl/gold_nic_pkg.sv
// Shared constants for the gold_nic processor/router network interface.
// Address codes select one of four registers in the processor window.
package gold_nic_pkg;

    localparam int DW     = 64;
    localparam int VC_BIT = 63;

    typedef enum logic [1:0] {
        ADDR_IN_DATA  = 2'b00,
        ADDR_IN_STAT  = 2'b01,
        ADDR_OUT_DATA = 2'b10,
        ADDR_OUT_STAT = 2'b11
    } nic_addr_e;

endpackage

// File: rtl/nic_buf.sv
// Single-entry packet buffer with a full flag. The caller must only assert load
// while empty and unload while full; data is kept after unload.
module nic_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         unload,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_d, full_q;
    logic [W-1:0] data_d, data_q;

    // NOTE: hold-value defaults first so no path through this block infers a latch.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (unload) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    // The data register is reset too, so a discarded packet never reappears on reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/gold_nic.sv
// Network interface between a processing element and a ring router PE port:
// register window, one ejection buffer and one polarity-gated injection buffer.
module gold_nic
    import gold_nic_pkg::*;
#(
    parameter int DW     = gold_nic_pkg::DW,
    parameter int VC_BIT = gold_nic_pkg::VC_BIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] d_out,
    input  logic          nicEn,
    input  logic          nicWrEn,
    input  logic          net_si,
    output logic          net_ri,
    input  logic [DW-1:0] net_di,
    output logic          net_so,
    input  logic          net_ro,
    output logic [DW-1:0] net_do,
    input  logic          net_polarity
);

    logic          rd_en, wr_en;
    logic          in_full, out_full;
    logic [DW-1:0] in_data, out_data;
    logic          in_load, in_unload, out_load;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

    // A read of an empty input buffer, or a write to a full output buffer, changes nothing.
    assign in_load   = net_si & ~in_full;
    assign in_unload = rd_en & (addr == ADDR_IN_DATA) & in_full;
    assign out_load  = wr_en & (addr == ADDR_OUT_DATA) & ~out_full;

    // Only send on the ring phase opposite to the packet's virtual-channel tag.
    assign net_so = out_full & net_ro & (out_data[VC_BIT] != net_polarity);
    assign net_ri = ~in_full;
    assign net_do = out_data;

    nic_buf #(.W(DW)) u_in_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (in_load),
        .load_data (net_di),
        .unload    (in_unload),
        .full      (in_full),
        .data      (in_data)
    );

    nic_buf #(.W(DW)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_data (d_in),
        .unload    (net_so),
        .full      (out_full),
        .data      (out_data)
    );

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (nic_addr_e'(addr))
                ADDR_IN_DATA:  d_out = in_data;
                ADDR_IN_STAT:  d_out = {{(DW-1){1'b0}}, in_full};
                ADDR_OUT_DATA: d_out = out_data;
                ADDR_OUT_STAT: d_out = {{(DW-1){1'b0}}, out_full};
            endcase
        end
    end

endmodule

// File: tb/tb_gold_nic.sv
// Bench for gold_nic: directed vector table, hand sequences for multi-cycle corners,
// then random traffic against a queue-based reference model.
module tb_gold_nic;
    import gold_nic_pkg::*;

    logic          clk, reset;
    logic [1:0]    addr;
    logic [DW-1:0] d_in, d_out, net_di, net_do;
    logic          nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

    int total = 0;
    int bad   = 0;

    gold_nic dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each buffer is a queue holding at most one packet, plus
    // the last value written into it (reads still show it after draining).
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] in_last, out_last;

    typedef struct {
        logic          en, we, si, ro, pol;
        logic [1:0]    a;
        logic [DW-1:0] din, di;
        logic          x_ri, x_so;
        logic [DW-1:0] x_do, x_dout;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        in_last  = '0;
        out_last = '0;
    endtask

    function automatic logic m_so();
        return out_q.size() == 1 && net_ro && (out_last[VC_BIT] != net_polarity);
    endfunction

    function automatic logic [DW-1:0] m_dout();
        if (!nicEn || nicWrEn) return '0;
        case (addr)
            2'b00:   return in_last;
            2'b01:   return DW'(in_q.size());
            2'b10:   return out_last;
            default: return DW'(out_q.size());
        endcase
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".ri"},   DW'(net_ri), DW'(in_q.size() == 0));
        check({tag, ".so"},   DW'(net_so), DW'(m_so()));
        check({tag, ".do"},   net_do, out_last);
        check({tag, ".dout"}, d_out, m_dout());
    endtask

    // Apply the clock edge to the model using the current (pre-edge) inputs.
    task automatic model_edge();
        bit sent, in_empty, out_empty;
        sent      = m_so();
        in_empty  = (in_q.size() == 0);
        out_empty = (out_q.size() == 0);
        if (in_empty && net_si) begin
            in_q.push_back(net_di);
            in_last = net_di;
        end else if (!in_empty && nicEn && !nicWrEn && addr == 2'b00) begin
            void'(in_q.pop_front());
        end
        if (sent) void'(out_q.pop_front());
        if (out_empty && nicEn && nicWrEn && addr == 2'b10) begin
            out_q.push_back(d_in);
            out_last = d_in;
        end
    endtask

    task automatic drive(input logic en, input logic we, input logic [1:0] a,
                         input logic [DW-1:0] din, input logic si, input logic [DW-1:0] di,
                         input logic ro, input logic pol);
        nicEn = en; nicWrEn = we; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    endtask

    task automatic idle(input logic ro, input logic pol);
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, '0, ro, pol);
    endtask

    // Called at posedge+1: settle, compare, update model, move to next posedge+1.
    task automatic step(input string tag);
        #2;
        check_model(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic en, logic we, logic [1:0] a, logic [DW-1:0] din,
                                logic si, logic [DW-1:0] di, logic ro, logic pol,
                                logic xri, logic xso, logic [DW-1:0] xdo, logic [DW-1:0] xdout);
        vec_t v;
        v.en = en; v.we = we; v.a = a; v.din = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.x_ri = xri; v.x_so = xso; v.x_do = xdo; v.x_dout = xdout;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] p1, p2;
        localparam logic [DW-1:0] AB  = 64'hAB;
        localparam logic [DW-1:0] HI  = 64'h8000_0000_0000_0001;
        localparam logic [DW-1:0] DB  = 64'hDEAD_BEEF;

        //           en we a      din  si di  ro pol   ri so do  dout
        vecs[0]  = mk(0, 0, 2'b00, '0,  0, '0, 0, 0,   1, 0, '0, '0);
        vecs[1]  = mk(1, 1, 2'b10, AB,  0, '0, 1, 1,   1, 0, '0, '0);
        vecs[2]  = mk(0, 0, 2'b00, '0,  0, '0, 1, 1,   1, 1, AB, '0);
        vecs[3]  = mk(1, 0, 2'b11, '0,  0, '0, 1, 1,   1, 0, AB, '0);
        vecs[4]  = mk(1, 1, 2'b10, HI,  0, '0, 1, 1,   1, 0, AB, '0);
        vecs[5]  = mk(1, 0, 2'b11, '0,  0, '0, 1, 1,   1, 0, HI, 64'd1);
        vecs[6]  = mk(1, 0, 2'b10, '0,  0, '0, 1, 0,   1, 1, HI, HI);
        vecs[7]  = mk(1, 0, 2'b11, '0,  0, '0, 1, 0,   1, 0, HI, '0);
        vecs[8]  = mk(1, 0, 2'b01, '0,  1, DB, 0, 0,   1, 0, HI, '0);
        vecs[9]  = mk(1, 0, 2'b01, '0,  0, '0, 0, 0,   0, 0, HI, 64'd1);
        vecs[10] = mk(1, 0, 2'b00, '0,  0, '0, 0, 0,   0, 0, HI, DB);
        vecs[11] = mk(1, 0, 2'b01, '0,  0, '0, 0, 0,   1, 0, HI, '0);
        vecs[12] = mk(1, 0, 2'b00, '0,  0, '0, 0, 0,   1, 0, HI, DB);

        reset = 1'b0;
        idle(1'b0, 1'b0);
        model_reset();
        #12;
        check("rst.ri", DW'(net_ri), DW'(1'b1));
        check("rst.so", DW'(net_so), DW'(1'b0));
        check("rst.do", net_do, '0);
        check("rst.dout", d_out, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table, kept in lock-step with the model.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].din, vecs[i].si, vecs[i].di,
                  vecs[i].ro, vecs[i].pol);
            #2;
            check($sformatf("vec%0d.ri", i),   DW'(net_ri), DW'(vecs[i].x_ri));
            check($sformatf("vec%0d.so", i),   DW'(net_so), DW'(vecs[i].x_so));
            check($sformatf("vec%0d.do", i),   net_do, vecs[i].x_do);
            check($sformatf("vec%0d.dout", i), d_out, vecs[i].x_dout);
            model_edge();
            @(posedge clk);
            #1;
        end

        // Backpressure: packet held for 5 cycles with net_ro low; second write dropped.
        drive(1'b1, 1'b1, 2'b10, 64'h11, 1'b0, '0, 1'b0, 1'b1);
        step("bp.wr1");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1'b1, 1'b1, 2'b10, 64'h55, 1'b0, '0, 1'b0, 1'b1);
            else        idle(1'b0, 1'b1);
            #2;
            check($sformatf("bp.hold%0d", i), DW'(net_so), '0);
            model_edge();
            @(posedge clk);
            #1;
        end
        idle(1'b1, 1'b1);
        #2;
        check("bp.send.so", DW'(net_so), DW'(1'b1));
        check("bp.send.do", net_do, 64'h11);
        model_edge();
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 2'b10, '0, 1'b0, '0, 1'b1, 1'b1);
        #2;
        check("bp.after.so", DW'(net_so), '0);
        check("bp.after.data", d_out, 64'h11);
        model_edge();
        @(posedge clk);
        #1;

        // Full input buffer: second packet waits until the data read frees the entry.
        p1 = 64'h0123_4567_89AB_CDEF;
        p2 = 64'hFEDC_BA98_7654_3210;
        drive(1'b0, 1'b0, 2'b00, '0, 1'b1, p1, 1'b0, 1'b0);
        step("fi.cap1");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b00, '0, 1'b1, p2, 1'b0, 1'b0);
            #2;
            check($sformatf("fi.blocked%0d", i), DW'(net_ri), '0);
            model_edge();
            @(posedge clk);
            #1;
        end
        drive(1'b1, 1'b0, 2'b00, '0, 1'b1, p2, 1'b0, 1'b0);
        #2;
        check("fi.read1", d_out, p1);
        model_edge();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, '0, 1'b1, p2, 1'b0, 1'b0);
        #2;
        check("fi.ri_free", DW'(net_ri), DW'(1'b1));
        model_edge();
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        check("fi.ri_taken", DW'(net_ri), '0);
        check("fi.read2", d_out, p2);
        model_edge();
        @(posedge clk);
        #1;

        // Mid-cycle reset with both buffers full.
        drive(1'b1, 1'b1, 2'b10, 64'h77, 1'b1, 64'h99, 1'b0, 1'b1);
        step("mr.fill");
        idle(1'b0, 1'b1);
        step("mr.full");
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b1, 1'b1);
        #2;
        check("mr.pre.so", DW'(net_so), DW'(1'b1));
        reset = 1'b0;
        model_reset();
        #1;
        check("mr.ri", DW'(net_ri), DW'(1'b1));
        check("mr.so", DW'(net_so), '0);
        check("mr.do", net_do, '0);
        drive(1'b1, 1'b0, 2'b01, '0, 1'b0, '0, 1'b1, 1'b1);
        #1;
        check("mr.stat_in", d_out, '0);
        addr = 2'b11;
        #1;
        check("mr.stat_out", d_out, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [DW-1:0] rd, rn;
            rd = {$urandom, $urandom};
            rn = {$urandom, $urandom};
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), rd, 1'($urandom_range(0, 1)), rn,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            step($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gold_nic.md
# gold_nic

Network interface controller between one processing element and the PE port of a ring router node. It provides a memory-mapped register window to the processor: one single-entry output buffer for injecting 64-bit packets into the router, and one single-entry input buffer for packets ejected by the router. Injection follows the router's even/odd virtual-channel polarity rule, so the block is the counterpart of the router's PE-side send/ready/data handshake.

## Interface
Parameters:
- DW, 64, packet width
- VC_BIT, 63, packet bit carrying the virtual-channel tag

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- addr  in  2  register select: 00 in-buf data, 01 in-buf status, 10 out-buf data, 11 out-buf status
- d_in  in  DW  processor write data
- d_out  out  DW  processor read data (combinational)
- nicEn  in  1  register access enable
- nicWrEn  in  1  1 = write, 0 = read (valid only with nicEn)
- net_si  in  1  router has a packet for the PE (router peso)
- net_ri  out  1  NIC can accept a packet (to router pero)
- net_di  in  DW  packet from router (router pedo)
- net_so  out  1  NIC injects a packet (to router pesi)
- net_ro  in  1  router PE input can accept (router peri)
- net_do  out  DW  packet to router (to router pedi)
- net_polarity  in  1  router's current polarity

## Operation
- State: in_buf[DW], in_full, out_buf[DW], out_full.
- Input channel: net_ri = ~in_full. When net_si & net_ri at a clock edge: in_buf <= net_di, in_full <= 1.
- Processor read, addr 00 (nicEn & ~nicWrEn): d_out = in_buf; if in_full, in_full <= 0 at that edge. Read while empty returns in_buf contents unchanged and leaves flags unchanged.
- Read addr 01: d_out = {63'b0, in_full}. Read addr 11: d_out = {63'b0, out_full}. Read addr 10: d_out = out_buf.
- d_out = 0 whenever nicEn = 0 or nicWrEn = 1.
- Processor write, addr 10: if ~out_full, out_buf <= d_in and out_full <= 1. A write while full is dropped, with no state change. Writes to 00, 01 and 11 are ignored.
- Output channel: net_do = out_buf. net_so = out_full & net_ro & (out_buf[VC_BIT] != net_polarity). On an edge where net_so = 1, out_full <= 0.
- Simultaneous events:
  - A net capture and a processor read of 00 in the same cycle cannot collide: capture requires the buffer empty, and a read while empty changes nothing.
  - A processor write to 10 in the same cycle out_buf drains is dropped, because out_full is still 1 in that cycle.

## Timing
- Reset (asynchronous assert, any cycle, including mid-transfer): in_full = 0, out_full = 0, in_buf = 0, out_buf = 0. Resulting outputs: net_ri = 1, net_so = 0, net_do = 0, d_out = 0 (nicEn low). Any pending packet is discarded.
- Net to processor: a packet captured at edge N shows in_full = 1 on the status read in cycle N+1. Earliest data read is cycle N+1; net_ri returns high after the read edge.
- Processor to net: a write at edge N makes out_full = 1 in cycle N+1. net_so rises combinationally in the first cycle ≥ N+1 with net_ro = 1 and the matching polarity. Worst-case extra wait is 1 cycle for polarity.
- Throughput: at most one packet per direction every 2 cycles (single-entry buffers).
- net_ri, net_so, net_do and d_out are combinational from registered state plus inputs. There is no combinational path from net_si to net_ri.

## Structure
- Shared package gold_nic_pkg: DW, VC_BIT, and address constants ADDR_IN_DATA = 2'b00, ADDR_IN_STAT = 2'b01, ADDR_OUT_DATA = 2'b10, ADDR_OUT_STAT = 2'b11.
- One sub-module, nic_buf: a single-entry buffer with a full flag and load/unload ports, instantiated twice (in and out). The top level holds the address decode, d_out mux and polarity gating.

## Test plan
- Reset: assert reset mid-cycle with both buffers full -> immediately net_ri = 1, net_so = 0, status reads 0/0.
- Injection: write 64'h0000_0000_0000_00AB to addr 10 with net_ro = 1 and net_polarity = 1 -> net_so = 1 and net_do = 64'hAB next cycle, status 11 reads 0 afterwards.
- Polarity hold: write 64'h8000_0000_0000_0001 while net_polarity = 1 -> net_so stays 0 until polarity = 0, then sends for exactly 1 cycle.
- Backpressure: out_full with net_ro = 0 for 5 cycles, plus a second write of 64'h55 -> no send and the second write is dropped; first packet sent once net_ro = 1.
- Ejection: net_si = 1 with 64'hDEAD_BEEF -> net_ri falls next cycle, status 01 = 1, read 00 returns 64'hDEAD_BEEF, net_ri high after the read edge.
- Full input: hold net_si = 1 with a second packet while in_full -> not accepted until after the read of 00; captured on the following edge.
